// File: rtl/scan_str_pkg.sv
// -----------------------------------------------------------------------------
// scan_str_pkg
// Shared definitions for the scan_str serial line receiver:
//   - ASCII control characters recognised by the line assembler
//   - state encoding of the byte receiver FSM
// -----------------------------------------------------------------------------
package scan_str_pkg;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage : scan_str_pkg

// File: rtl/scan_str_if.sv
// -----------------------------------------------------------------------------
// scan_str_if
// Message handshake between scan_str (master, producer) and the command parser
// (slave, consumer).
//   message   : completed line, character 0 in the least-significant byte
//   msg_len   : number of characters in message (0..STR_LEN)
//   msg_valid : message/msg_len hold an unconsumed line
//   msg_ack   : consumer accepts the line (ignored while msg_valid is low)
//   truncated : line was cut at STR_LEN characters, qualified by msg_valid
// -----------------------------------------------------------------------------
interface scan_str_if #(
  parameter int STR_LEN = 13
);

  logic [0:STR_LEN*8-1] message;
  logic [7:0]           msg_len;
  logic                 msg_valid;
  logic                 msg_ack;
  logic                 truncated;

  modport master (
    output message,
    output msg_len,
    output msg_valid,
    output truncated,
    input  msg_ack
  );

  modport slave (
    input  message,
    input  msg_len,
    input  msg_valid,
    input  truncated,
    output msg_ack
  );

endinterface : scan_str_if

// File: rtl/scan_str_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver: 2-flop synchroniser on the serial line followed by a
// START/DATA/STOP sampling FSM.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   rx_i         : serial line, idle high, asynchronous to clk
//   rx_byte_o    : last received byte (valid with rx_strobe_o)
//   rx_strobe_o  : one-cycle pulse, byte received with a good stop bit
//   frame_err_o  : one-cycle pulse, stop bit sampled low (byte dropped)
//   active_o     : a frame is in progress (FSM not idle)
// -----------------------------------------------------------------------------
module uart_rx_byte
  import scan_str_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_strobe_o,
  output logic       frame_err_o,
  output logic       active_o
);

  localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             prev_q;
  logic [2:0]       prime_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             strobe_q, strobe_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;
  logic             fall_s;

  assign rx_s = sync_q[1];

  // prime_q marks when prev_q holds a genuine line sample rather than its
  // reset value, so a line already low at reset release is not taken as a
  // start edge; it must first return high.
  assign fall_s = prime_q[2] & prev_q & ~rx_s;

  // Synchroniser, edge-detect history and priming shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      prime_q <= 3'b000;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      prime_q <= {prime_q[1:0], 1'b1};
    end
  end

  // Receiver FSM state, counters and registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end

  // Receiver FSM next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        // Mid start bit: a high line here means the edge was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        // Back to idle right at the stop sample so a following start bit
        // is caught without losing half a bit.
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          state_d  = RX_IDLE;
          strobe_d = rx_s;
          ferr_d   = ~rx_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_byte_o   = shift_q;
  assign rx_strobe_o = strobe_q;
  assign frame_err_o = ferr_q;
  assign active_o    = (state_q != RX_IDLE);

endmodule : uart_rx_byte

// File: rtl/scan_str.sv
// -----------------------------------------------------------------------------
// scan_str
// Receives 8N1 UART characters, assembles them into a null-padded line buffer
// and hands each completed line to the consumer via a valid/ack interface.
// CR is dropped, LF ends a line, a full buffer ends a line as truncated.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   rx_i         : serial input line, idle high
//   msg_if       : message handshake (master side)
//   overrun_o    : sticky, a completed line was discarded (output occupied)
//   frame_err_o  : one-cycle pulse, stop bit sampled low
//   busy_o       : frame in progress or line buffer non-empty
// -----------------------------------------------------------------------------
module scan_str
  import scan_str_pkg::*;
#(
  parameter int STR_LEN      = 13,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  scan_str_if.master  msg_if,
  output logic        overrun_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  localparam int MSG_W = STR_LEN * 8;

  logic [7:0]       rx_byte_s;
  logic             rx_strobe_s;
  logic             rx_active_s;

  logic [0:MSG_W-1] buf_q, buf_d;
  logic [7:0]       count_q, count_d;
  logic             done_q, done_d;
  logic             done_trunc_q, done_trunc_d;
  logic [0:MSG_W-1] message_q, message_d;
  logic [7:0]       msg_len_q, msg_len_d;
  logic             msg_valid_q, msg_valid_d;
  logic             trunc_q, trunc_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .rx_byte_o   (rx_byte_s),
    .rx_strobe_o (rx_strobe_s),
    .frame_err_o (frame_err_o),
    .active_o    (rx_active_s)
  );

  // Line assembler and output handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q        <= '0;
      count_q      <= 8'd0;
      done_q       <= 1'b0;
      done_trunc_q <= 1'b0;
      message_q    <= '0;
      msg_len_q    <= 8'd0;
      msg_valid_q  <= 1'b0;
      trunc_q      <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      count_q      <= count_d;
      done_q       <= done_d;
      done_trunc_q <= done_trunc_d;
      message_q    <= message_d;
      msg_len_q    <= msg_len_d;
      msg_valid_q  <= msg_valid_d;
      trunc_q      <= trunc_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  // Assembler / completion next-state logic. done_q marks a line finished
  // by the previous strobe; the hand-off happens one cycle later. A strobe
  // can never coincide with done_q since bytes are ten bit-times apart.
  always_comb begin
    buf_d        = buf_q;
    count_d      = count_q;
    done_d       = 1'b0;
    done_trunc_d = 1'b0;
    message_d    = message_q;
    msg_len_d    = msg_len_q;
    msg_valid_d  = msg_valid_q;
    trunc_d      = trunc_q;
    overrun_d    = overrun_q;

    if (done_q) begin
      buf_d   = '0;
      count_d = 8'd0;
      if (!msg_valid_q || msg_if.msg_ack) begin
        message_d   = buf_q;
        msg_len_d   = count_q;
        msg_valid_d = 1'b1;
        trunc_d     = done_trunc_q;
        overrun_d   = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      if (msg_valid_q && msg_if.msg_ack) begin
        msg_valid_d = 1'b0;
        overrun_d   = 1'b0;
      end else begin
        msg_valid_d = msg_valid_q;
      end

      if (rx_strobe_s) begin
        case (rx_byte_s)
          CHAR_CR: begin
            count_d = count_q;
          end
          CHAR_LF: begin
            done_d = 1'b1;
          end
          default: begin
            // Character k sits in byte lane STR_LEN-1-k of the ascending
            // vector, i.e. character 0 lands in the least-significant byte.
            for (int k = 0; k < STR_LEN; k++) begin
              buf_d[(STR_LEN-1-k)*8 +: 8] =
                (count_q == 8'(k)) ? rx_byte_s : buf_q[(STR_LEN-1-k)*8 +: 8];
            end
            count_d = count_q + 8'd1;
            if (count_d == 8'(STR_LEN)) begin
              done_d       = 1'b1;
              done_trunc_d = 1'b1;
            end else begin
              done_d = 1'b0;
            end
          end
        endcase
      end else begin
        count_d = count_q;
      end
    end

    busy_d = rx_active_s || (count_d != 8'd0) || done_d;
  end

  assign msg_if.message   = message_q;
  assign msg_if.msg_len   = msg_len_q;
  assign msg_if.msg_valid = msg_valid_q;
  assign msg_if.truncated = trunc_q;
  assign overrun_o        = overrun_q;
  assign busy_o           = busy_q;

endmodule : scan_str

// File: tb/tb_scan_str.sv
// -----------------------------------------------------------------------------
// tb_scan_str
// Directed bench for scan_str with CLKS_PER_BIT = 16 and STR_LEN = 4.
// -----------------------------------------------------------------------------
module tb_scan_str;

  localparam int CPB  = 16;
  localparam int SLEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic overrun_o, frame_err_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cycles = 0;
  int strobe_cnt = 0;
  int fe0, st0;

  scan_str_if #(.STR_LEN(SLEN)) msg_if ();

  scan_str #(
    .STR_LEN      (SLEN),
    .CLKS_PER_BIT (CPB)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx),
    .msg_if      (msg_if.master),
    .overrun_o   (overrun_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err_o) fe_cycles <= fe_cycles + 1;
    if (u_dut.rx_strobe_s) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_bit);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!msg_if.msg_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, msg_if.msg_valid}, 32'd1);
  endtask

  task automatic ack();
    msg_if.msg_ack = 1'b1;
    @(negedge clk);
    msg_if.msg_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    msg_if.msg_ack = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_valid", {31'd0, msg_if.msg_valid}, 32'd0);
    check_eq("rst_len", {24'd0, msg_if.msg_len}, 32'd0);
    check_eq("rst_msg", msg_if.message, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // "AB\n"
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_valid("ab_valid");
    check_eq("ab_len", {24'd0, msg_if.msg_len}, 32'd2);
    check_eq("ab_msg", msg_if.message, 32'h0000_4241);
    check_eq("ab_trunc", {31'd0, msg_if.truncated}, 32'd0);
    ack();
    check_eq("ab_ack_valid", {31'd0, msg_if.msg_valid}, 32'd0);
    check_eq("ab_ack_msg_kept", msg_if.message, 32'h0000_4241);

    // "ABCDE\n": truncated after D, then "E"
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_valid("tr_valid");
    check_eq("tr_msg", msg_if.message, 32'h4443_4241);
    check_eq("tr_len", {24'd0, msg_if.msg_len}, 32'd4);
    check_eq("tr_trunc", {31'd0, msg_if.truncated}, 32'd1);
    ack();
    send_byte(8'h45, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_valid("e_valid");
    check_eq("e_len", {24'd0, msg_if.msg_len}, 32'd1);
    check_eq("e_msg", msg_if.message, 32'h0000_0045);
    check_eq("e_trunc", {31'd0, msg_if.truncated}, 32'd0);
    ack();

    // "A\r\n" then empty line
    send_byte(8'h41, 1'b1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_valid("cr_valid");
    check_eq("cr_len", {24'd0, msg_if.msg_len}, 32'd1);
    check_eq("cr_msg", msg_if.message, 32'h0000_0041);
    ack();
    send_byte(8'h0A, 1'b1);
    wait_valid("empty_valid");
    check_eq("empty_len", {24'd0, msg_if.msg_len}, 32'd0);
    check_eq("empty_msg", msg_if.message, 32'd0);
    ack();

    // framing error then "B\n"
    fe0 = fe_cycles;
    st0 = strobe_cnt;
    send_byte(8'h41, 1'b0);
    check_eq("fe_pulse_cycles", fe_cycles - fe0, 32'd1);
    check_eq("fe_no_strobe", strobe_cnt - st0, 32'd0);
    send_byte(8'h42, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_valid("fe_b_valid");
    check_eq("fe_b_msg", msg_if.message, 32'h0000_0042);
    check_eq("fe_b_len", {24'd0, msg_if.msg_len}, 32'd1);
    ack();

    // overrun: "X\n" unacked, then "Y\n"
    send_byte(8'h58, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_valid("x_valid");
    check_eq("x_overrun_pre", {31'd0, overrun_o}, 32'd0);
    send_byte(8'h59, 1'b1);
    send_byte(8'h0A, 1'b1);
    check_eq("ov_overrun", {31'd0, overrun_o}, 32'd1);
    check_eq("ov_msg", msg_if.message, 32'h0000_0058);
    check_eq("ov_valid", {31'd0, msg_if.msg_valid}, 32'd1);
    ack();
    check_eq("ov_ack_valid", {31'd0, msg_if.msg_valid}, 32'd0);
    check_eq("ov_ack_overrun", {31'd0, overrun_o}, 32'd0);

    // reset in the middle of the second data bit of 'Q' (0x51)
    bit_time(1'b0);
    bit_time(1'b1);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    check_eq("q_busy_mid", {31'd0, busy_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("q_rst_msg", msg_if.message, 32'd0);
    check_eq("q_rst_len", {24'd0, msg_if.msg_len}, 32'd0);
    check_eq("q_rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("q_rst_flags", {28'd0, msg_if.msg_valid, msg_if.truncated, overrun_o, frame_err_o}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    st0 = strobe_cnt;
    repeat (30) @(negedge clk);
    check_eq("q_low_no_strobe", strobe_cnt - st0, 32'd0);
    check_eq("q_low_busy", {31'd0, busy_o}, 32'd0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_valid("z_valid");
    check_eq("z_msg", msg_if.message, 32'h0000_005A);
    check_eq("z_len", {24'd0, msg_if.msg_len}, 32'd1);
    ack();

    // 4-cycle low glitch
    st0 = strobe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch_no_strobe", strobe_cnt - st0, 32'd0);
    check_eq("glitch_busy", {31'd0, busy_o}, 32'd0);
    send_byte(8'h0A, 1'b1);
    wait_valid("glitch_lf_valid");
    check_eq("glitch_lf_len", {24'd0, msg_if.msg_len}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_scan_str
